// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_strobe input-conditioning stage:
// debounce FSM state encoding and default stability count.
package debounce_pkg;

  localparam int unsigned DB_STABLE_CNT_DEF = 50000;
  localparam int unsigned DB_CNT_W_DEF      = 16;

  // Bit 1 of the encoding is the debounced level.
  typedef enum logic [1:0] {
    S_LO      = 2'b00,
    S_WAIT_HI = 2'b01,
    S_HI      = 2'b11,
    S_WAIT_LO = 2'b10
  } db_state_e;

endpackage

// File: rtl/debounce_cell.sv
// One debounce channel: optional 2-flop synchronizer (DEBOUNCE_SYNC_2FF_EN),
// stability FSM with counter, debounced level and registered rise pulse.
module debounce_cell
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DB_STABLE_CNT_DEF,
  parameter int unsigned CNT_W      = DB_CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sample;

`ifdef DEBOUNCE_SYNC_2FF_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[0], raw_i};
  end

  assign sample = sync_q[1];
`else
  assign sample = raw_i;
`endif

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  // Counter defaults to 0 so it is held clear in the stable states.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_LO: begin
        if (sample) begin
          state_d = S_WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT_HI: begin
        if (!sample)                state_d = S_LO;
        else if (cnt_q == CNT_LAST) state_d = S_HI;
        else                        cnt_d   = cnt_q + CNT_ONE;
      end
      S_HI: begin
        if (!sample) begin
          state_d = S_WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT_LO: begin
        if (sample)                 state_d = S_HI;
        else if (cnt_q == CNT_LAST) state_d = S_LO;
        else                        cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = S_LO;
    endcase
  end

  always_comb begin
    level_o = (state_q == S_HI) || (state_q == S_WAIT_LO);
    rise_d  = (state_q == S_WAIT_HI) && (state_d == S_HI);
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/debounce_strobe.sv
// Debounces a data switch and an enable button for a downstream D latch;
// DEBOUNCE_SYNC_2FF_EN adds a 2-flop synchronizer in front of each channel.
module debounce_strobe
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DB_STABLE_CNT_DEF,
  parameter int unsigned CNT_W      = DB_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  input  logic btn_raw,
  output logic D,
  output logic en,
  output logic btn_lvl
);

  logic sw_rise_unused;

  debounce_cell #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) u_data (
    .clk_i   (clk),
    .rst_i   (rst),
    .raw_i   (sw_raw),
    .level_o (D),
    .rise_o  (sw_rise_unused)
  );

  debounce_cell #(
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) u_enable (
    .clk_i   (clk),
    .rst_i   (rst),
    .raw_i   (btn_raw),
    .level_o (btn_lvl),
    .rise_o  (en)
  );

endmodule
